// File: rtl/prio_encoder_queue.sv
// prio_encoder_queue
// Registered priority encoder with sticky request capture and a single
// valid/ready output slot. Any high req_in bit is latched as pending; one
// winner per accepted transfer moves from pending into the output slot. The
// winner is reported as a binary index and as a one-hot vector.
//
// Build option: define ROUND_ROBIN_EN to replace the fixed lowest-index-wins
// priority with a round-robin search. The search starts just after the last
// granted index.
module prio_encoder_queue #(
  parameter  int WIDTH = 8,
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] req_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_pos,
  output logic [WIDTH-1:0] out_onehot,
  output logic [WIDTH-1:0] pending
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] pos_q, pos_d;
  logic [WIDTH-1:0] onehot_q, onehot_d;
  logic [WIDTH-1:0] pending_q, pending_d;

  logic [WIDTH-1:0] cand;
  logic             cand_any;
  logic             load;
  logic [IDX_W-1:0] win;

`ifdef ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  // First set bit searching ptr+1, ptr+2, ... with wrap; ptr itself is visited last.
  function automatic logic [IDX_W-1:0] pick_rr(input logic [WIDTH-1:0] c,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] k;
    logic             found;
    int               idx;
    k     = '0;
    found = 1'b0;
    for (int off = 1; off <= WIDTH; off++) begin
      idx = (int'(ptr) + off) % WIDTH;
      if (!found && c[idx]) begin
        k     = IDX_W'(idx);
        found = 1'b1;
      end
    end
    return k;
  endfunction
`else
  // Lowest set index wins; bit 0 has the highest priority.
  function automatic logic [IDX_W-1:0] pick_fixed(input logic [WIDTH-1:0] c);
    logic [IDX_W-1:0] k;
    k = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (c[i]) k = IDX_W'(i);
    end
    return k;
  endfunction
`endif

  // Winner selection, slot load decision and next-state for the output slot
  always_comb begin
    cand     = pending_q | req_in;
    cand_any = |cand;
    load     = (state_q == EMPTY) || out_ready;
`ifdef ROUND_ROBIN_EN
    win      = pick_rr(cand, rr_ptr_q);
    rr_ptr_d = rr_ptr_q;
`else
    win      = pick_fixed(cand);
`endif
    state_d   = state_q;
    pos_d     = pos_q;
    onehot_d  = onehot_q;
    pending_d = cand;
    if (load) begin
      if (cand_any) begin
        state_d   = FULL;
        pos_d     = win;
        onehot_d  = WIDTH'(1) << win;
        // The winner leaves pending; a same-cycle req_in of the winner is consumed by this grant.
        pending_d = cand & ~(WIDTH'(1) << win);
`ifdef ROUND_ROBIN_EN
        rr_ptr_d  = win;
`endif
      end else begin
        state_d  = EMPTY;
        pos_d    = '0;
        onehot_d = '0;
      end
    end
  end

  // Slot occupancy state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Granted index, one-hot and pending capture; reset discards everything in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q     <= '0;
      onehot_q  <= '0;
      pending_q <= '0;
`ifdef ROUND_ROBIN_EN
      rr_ptr_q  <= IDX_W'(WIDTH - 1);
`endif
    end else begin
      pos_q     <= pos_d;
      onehot_q  <= onehot_d;
      pending_q <= pending_d;
`ifdef ROUND_ROBIN_EN
      rr_ptr_q  <= rr_ptr_d;
`endif
    end
  end

  assign out_valid  = (state_q == FULL);
  assign out_pos    = pos_q;
  assign out_onehot = onehot_q;
  assign pending    = pending_q;

endmodule

// File: tb/tb_prio_encoder_queue.sv
// Testbench for prio_encoder_queue (WIDTH=8). A behavioural model of the
// pending set and the output slot is checked against the DUT every cycle.
// Directed scenarios also carry hand-computed literal expectations.
module tb_prio_encoder_queue;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] req_in = '0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [2:0]   out_pos;
  logic [W-1:0] out_onehot;
  logic [W-1:0] pending;

  int n_cmp = 0;
  int n_bad = 0;

  prio_encoder_queue #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_in     (req_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pos    (out_pos),
    .out_onehot (out_onehot),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic         m_known = 1'b0;
  logic         m_valid = 1'b0;
  int           m_pos = 0;
  logic [W-1:0] m_pend = '0;
  int           m_ptr = W - 1;

  always @(posedge clk) begin : model
    bit c[W];
    bit any;
    int k;
    int idx;
    logic [W-1:0] np;
    if (reset) begin
      m_known <= 1'b1;
      m_valid <= 1'b0;
      m_pos   <= 0;
      m_pend  <= '0;
      m_ptr   <= W - 1;
    end else begin
      any = 0;
      k   = -1;
      for (int i = 0; i < W; i++) begin
        c[i] = m_pend[i] | req_in[i];
        if (c[i]) any = 1;
      end
      if (!m_valid || out_ready) begin
        if (any) begin
`ifdef ROUND_ROBIN_EN
          for (int j = 1; j <= W; j++) begin
            idx = (m_ptr + j) % W;
            if (k < 0 && c[idx]) k = idx;
          end
`else
          for (int i = 0; i < W; i++) if (k < 0 && c[i]) k = i;
`endif
          c[k] = 0;
          m_valid <= 1'b1;
          m_pos   <= k;
          m_ptr   <= k;
        end else begin
          m_valid <= 1'b0;
          m_pos   <= 0;
        end
      end
      np = '0;
      for (int i = 0; i < W; i++) np[i] = c[i];
      m_pend <= np;
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (m_known) begin
      chk("model_valid",   32'(out_valid),  32'(m_valid));
      chk("model_pos",     32'(out_pos),    32'(m_pos));
      chk("model_onehot",  32'(out_onehot), m_valid ? (32'd1 << m_pos) : 32'd0);
      chk("model_pending", 32'(pending),    32'(m_pend));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  int exp5[10];

  initial begin
`ifdef ROUND_ROBIN_EN
    exp5 = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
`else
    exp5 = '{0, 0, 0, 1, 2, 3, 4, 5, 6, 7};
`endif
    // 1: reset then idle
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t1_valid",   32'(out_valid),  0);
      chk("t1_pos",     32'(out_pos),    0);
      chk("t1_onehot",  32'(out_onehot), 0);
      chk("t1_pending", 32'(pending),    0);
    end

    // 2: one-cycle pulse of 1010_0100 drains as 2,5,7
    req_in = 8'b1010_0100;
    tick();
    req_in = '0;
    chk("t2_valid0",  32'(out_valid), 1);
    chk("t2_pos0",    32'(out_pos),   2);
    chk("t2_oh0",     32'(out_onehot), 'h04);
    chk("t2_pend0",   32'(pending),   'hA0);
    tick();
    chk("t2_pos1",    32'(out_pos),   5);
    tick();
    chk("t2_pos2",    32'(out_pos),   7);
    chk("t2_oh2",     32'(out_onehot), 'h80);
    tick();
    chk("t2_empty",   32'(out_valid), 0);

    // 3: stall holds pos 4 while req 0 accumulates
    out_ready = 1'b0;
    req_in = 8'h10;
    tick();
    req_in = 8'h01;
    chk("t3_pos4",    32'(out_pos),   4);
    tick();
    req_in = '0;
    tick();
    chk("t3_hold",    32'(out_pos),   4);
    chk("t3_pend",    32'(pending),   'h01);
    out_ready = 1'b1;
    tick();
    chk("t3_next",    32'(out_pos),   0);
    chk("t3_nextv",   32'(out_valid), 1);
    tick();
    chk("t3_empty",   32'(out_valid), 0);

    // 4: re-assert bit 3 while it sits in the stalled slot
    out_ready = 1'b0;
    req_in = 8'h08;
    tick();
    chk("t4_pos3",    32'(out_pos),   3);
    req_in = 8'h08;
    tick();
    req_in = '0;
    chk("t4_pend3",   32'(pending),   'h08);
    out_ready = 1'b1;
    tick();
    chk("t4_second",  32'(out_pos),   3);
    chk("t4_secondv", 32'(out_valid), 1);
    chk("t4_pend0",   32'(pending),   0);
    tick();
    chk("t4_empty",   32'(out_valid), 0);

    // 5: all requests held three cycles
    do_reset();
    req_in = 8'hFF;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 2) req_in = '0;
      chk("t5_valid", 32'(out_valid), 1);
      chk("t5_pos",   32'(out_pos),   32'(exp5[i]));
    end
    tick();
    chk("t5_empty",   32'(out_valid), 0);

    // 6: reset with a grant in flight and 2/3 pending
    do_reset();
    out_ready = 1'b0;
    req_in = 8'h0E;
    tick();
    chk("t6_pos1",    32'(out_pos),   1);
    chk("t6_pend",    32'(pending),   'h0C);
    req_in = 8'hFF;
    reset = 1'b1;
    tick();
    chk("t6_rvalid",  32'(out_valid), 0);
    chk("t6_rpend",   32'(pending),   0);
    chk("t6_roh",     32'(out_onehot), 0);
    reset = 1'b0;
    req_in = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t6_novalid", 32'(out_valid), 0);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
